// File: rtl/square_voice_ctrl.sv
// Per-voice controller for one DDS square channel: note-on/note-off command intake
// and a tick-paced attack/sustain/release volume envelope.
module square_voice_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int VOL_WIDTH   = 6,
    parameter int STEP_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_active_low,
    input  logic                   tick,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_note_on,
    input  logic [PHASE_WIDTH-1:0] cmd_freq_word,
    input  logic [VOL_WIDTH-1:0]   cmd_target_vol,
    input  logic [STEP_WIDTH-1:0]  attack_step,
    input  logic [STEP_WIDTH-1:0]  release_step,
    output logic [PHASE_WIDTH-1:0] freq_word,
    output logic [VOL_WIDTH-1:0]   vol,
    output logic                   phase_rst,
    output logic [2:0]             state,
    output logic                   active
);

    // Envelope arithmetic is done one bit wider than vol so attack sums never wrap.
    localparam int EW = VOL_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ATTACK  = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] freq_q, freq_d;
    logic [VOL_WIDTH-1:0]   vol_q, vol_d;
    logic [VOL_WIDTH-1:0]   target_q, target_d;
    logic                   prst_q, prst_d;

    logic                   accept;
    logic [EW-1:0]          atk_ext;
    logic [EW-1:0]          rel_ext;
    logic [EW-1:0]          vol_ext;
    logic [EW-1:0]          tgt_ext;
    logic [EW-1:0]          atk_sum;
    logic [EW-1:0]          rel_diff;

    // Valid/ready: a command is consumed on every rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready drops only during the one-cycle LOAD state.
    assign cmd_ready = (state_q != ST_LOAD);
    assign accept    = cmd_valid & cmd_ready;

    assign atk_ext  = EW'(attack_step);
    assign rel_ext  = EW'(release_step);
    assign vol_ext  = EW'(vol_q);
    assign tgt_ext  = EW'(target_q);
    assign atk_sum  = vol_ext + atk_ext;
    assign rel_diff = vol_ext - rel_ext;

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            vol_q    <= '0;
            target_q <= '0;
            prst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            vol_q    <= vol_d;
            target_q <= target_d;
            prst_q   <= prst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        vol_d    = vol_q;
        target_d = target_q;
        prst_d   = 1'b0;

        // An accepted command always takes priority; a coincident tick is dropped.
        if (accept && cmd_note_on) begin
            state_d  = ST_LOAD;
            freq_d   = cmd_freq_word;
            target_d = cmd_target_vol;
            vol_d    = '0;
            prst_d   = 1'b1;
        end else if (accept) begin
            if (state_q == ST_ATTACK || state_q == ST_SUSTAIN) begin
                state_d = ST_RELEASE;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (tick) begin
                        if (attack_step == '0 || atk_sum >= tgt_ext) begin
                            vol_d   = target_q;
                            state_d = ST_SUSTAIN;
                        end else begin
                            vol_d = atk_sum[VOL_WIDTH-1:0];
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tick) begin
                        if (release_step == '0 || vol_ext <= rel_ext) begin
                            vol_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            vol_d = rel_diff[VOL_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign freq_word = freq_q;
    assign vol       = vol_q;
    assign phase_rst = prst_q;
    assign state     = state_q;
    assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_square_voice_ctrl.sv
// Bench for square_voice_ctrl: directed envelope scenarios plus randomized command
// and tick traffic, compared each cycle against a behavioural envelope model.
module tb_square_voice_ctrl;

  localparam int PW = 32;
  localparam int VW = 6;
  localparam int SW = 4;

  logic          clk;
  logic          rst_active_low;
  logic          tick;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_note_on;
  logic [PW-1:0] cmd_freq_word;
  logic [VW-1:0] cmd_target_vol;
  logic [SW-1:0] attack_step;
  logic [SW-1:0] release_step;
  logic [PW-1:0] freq_word;
  logic [VW-1:0] vol;
  logic          phase_rst;
  logic [2:0]    state;
  logic          active;

  int n_checks;
  int n_errors;

  // reference model: note phase as a small integer (0 idle, 1 load, 2 attack, 3 sustain, 4 release)
  int      m_phase;
  int      m_vol;
  int      m_tgt;
  logic [PW-1:0] m_freq;
  bit      m_prst;

  square_voice_ctrl #(
    .PHASE_WIDTH(PW),
    .VOL_WIDTH  (VW),
    .STEP_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst_active_low(rst_active_low),
    .tick          (tick),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_note_on   (cmd_note_on),
    .cmd_freq_word (cmd_freq_word),
    .cmd_target_vol(cmd_target_vol),
    .attack_step   (attack_step),
    .release_step  (release_step),
    .freq_word     (freq_word),
    .vol           (vol),
    .phase_rst     (phase_rst),
    .state         (state),
    .active        (active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_vol   = 0;
    m_tgt   = 0;
    m_freq  = '0;
    m_prst  = 0;
  endtask

  // Advances the model by one clock edge given the current inputs.
  task automatic model_edge();
    bit take;
    int a;
    int r;
    take = cmd_valid && (m_phase != 1);
    a = int'(attack_step);
    r = int'(release_step);
    m_prst = 0;
    if (take && cmd_note_on) begin
      m_phase = 1;
      m_freq  = cmd_freq_word;
      m_tgt   = int'(cmd_target_vol);
      m_vol   = 0;
      m_prst  = 1;
    end else if (take) begin
      if (m_phase == 2 || m_phase == 3) m_phase = 4;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (tick && m_phase == 2) begin
      if (a == 0 || m_vol + a >= m_tgt) begin
        m_vol = m_tgt;
        m_phase = 3;
      end else begin
        m_vol = m_vol + a;
      end
    end else if (tick && m_phase == 4) begin
      if (r == 0 || m_vol <= r) begin
        m_vol = 0;
        m_phase = 0;
      end else begin
        m_vol = m_vol - r;
      end
    end
  endtask

  task automatic compare_model();
    check("state", 64'(state), 64'(m_phase));
    check("vol", 64'(vol), 64'(m_vol));
    check("freq_word", 64'(freq_word), 64'(m_freq));
    check("phase_rst", 64'(phase_rst), 64'(m_prst));
    check("cmd_ready", 64'(cmd_ready), 64'(m_phase != 1));
    check("active", 64'(active), 64'(m_phase != 0));
  endtask

  // driver: one clock edge with the currently driven inputs, then sample and compare
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    tick = 0;
    cmd_valid = 0;
    cmd_note_on = 0;
  endtask

  task automatic note_on(input logic [PW-1:0] f, input int tgt);
    cmd_valid = 1;
    cmd_note_on = 1;
    cmd_freq_word = f;
    cmd_target_vol = VW'(tgt);
    step();
    idle_inputs();
  endtask

  task automatic note_off();
    cmd_valid = 1;
    cmd_note_on = 0;
    cmd_freq_word = PW'($urandom);
    cmd_target_vol = VW'($urandom);
    step();
    idle_inputs();
  endtask

  task automatic do_tick();
    tick = 1;
    step();
    tick = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_active_low = 0;
    idle_inputs();
    cmd_freq_word = '0;
    cmd_target_vol = '0;
    attack_step = '0;
    release_step = '0;
    model_reset();

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_active_low = 1;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_vol", 64'(vol), 64'd0);
    check("rst_freq", 64'(freq_word), 64'd0);
    check("rst_prst", 64'(phase_rst), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // attack ramp
    attack_step = 4'd6;
    note_on(32'h0100_0000, 20);
    check("on_prst", 64'(phase_rst), 64'd1);
    check("on_state", 64'(state), 64'd1);
    check("on_freq", 64'(freq_word), 64'h0100_0000);
    check("load_ready", 64'(cmd_ready), 64'd0);
    tick = 1;
    step();
    tick = 0;
    check("load_tick_ignored", 64'(vol), 64'd0);
    check("prst_one_cycle", 64'(phase_rst), 64'd0);
    check("to_attack", 64'(state), 64'd2);
    do_tick(); check("atk_vol1", 64'(vol), 64'd6);
    do_tick(); check("atk_vol2", 64'(vol), 64'd12);
    do_tick(); check("atk_vol3", 64'(vol), 64'd18);
    do_tick(); check("atk_vol4", 64'(vol), 64'd20);
    check("atk_sustain", 64'(state), 64'd3);
    do_tick(); check("sus_hold", 64'(vol), 64'd20);

    // release
    release_step = 4'd7;
    note_off();
    check("off_state", 64'(state), 64'd4);
    check("off_vol", 64'(vol), 64'd20);
    do_tick(); check("rel_vol1", 64'(vol), 64'd13);
    do_tick(); check("rel_vol2", 64'(vol), 64'd6);
    do_tick(); check("rel_vol3", 64'(vol), 64'd0);
    check("rel_idle", 64'(state), 64'd0);
    check("rel_inactive", 64'(active), 64'd0);
    note_off();
    check("idle_off_ignored", 64'(state), 64'd0);

    // retrigger from RELEASE at vol 13
    attack_step = 4'd0;
    note_on(32'h0100_0000, 20);
    step();
    do_tick(); check("instant_atk", 64'(vol), 64'd20);
    note_off();
    do_tick(); check("retrig_pre_vol", 64'(vol), 64'd13);
    attack_step = 4'd6;
    note_on(32'h0200_0000, 20);
    check("retrig_state", 64'(state), 64'd1);
    check("retrig_vol", 64'(vol), 64'd0);
    check("retrig_freq", 64'(freq_word), 64'h0200_0000);
    check("retrig_ready", 64'(cmd_ready), 64'd0);
    step();
    check("retrig_attack", 64'(state), 64'd2);

    // collision: tick and note-off on the same edge
    do_tick(); check("col_pre_vol", 64'(vol), 64'd6);
    tick = 1;
    note_off();
    tick = 0;
    check("col_state", 64'(state), 64'd4);
    check("col_vol", 64'(vol), 64'd6);

    // release_step = 0 -> instant silence
    release_step = 4'd0;
    do_tick();
    check("rel0_vol", 64'(vol), 64'd0);
    check("rel0_state", 64'(state), 64'd0);

    // attack_step = 0, target 63
    attack_step = 4'd0;
    note_on(32'h0000_1234, 63);
    step();
    do_tick();
    check("atk0_vol", 64'(vol), 64'd63);
    check("atk0_state", 64'(state), 64'd3);

    // target 0 goes straight to SUSTAIN at vol 0
    attack_step = 4'd3;
    note_on(32'h0000_5678, 0);
    step();
    do_tick();
    check("tgt0_vol", 64'(vol), 64'd0);
    check("tgt0_state", 64'(state), 64'd3);

    // async reset mid-ATTACK
    attack_step = 4'd5;
    note_on(32'h0300_0000, 50);
    step();
    do_tick();
    check("pre_rst_vol", 64'(vol), 64'd5);
    #2;
    rst_active_low = 0;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_vol", 64'(vol), 64'd0);
    check("arst_freq", 64'(freq_word), 64'd0);
    check("arst_active", 64'(active), 64'd0);
    model_reset();
    @(negedge clk);
    rst_active_low = 1;
    #1;
    compare_model();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 25);
      cmd_note_on = ($urandom_range(0, 1) == 1);
      cmd_freq_word = PW'($urandom);
      cmd_target_vol = VW'($urandom_range(0, 63));
      attack_step = SW'($urandom_range(0, 15));
      release_step = SW'($urandom_range(0, 15));
      tick = ($urandom_range(0, 99) < 30);
      step();
    end
    idle_inputs();

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
